// File: rtl/bram_pkg.sv
// Shared types and helpers for the masked simple-dual-port block RAM.
package bram_pkg;

  localparam int unsigned MAX_DATA_W  = 64;
  localparam int unsigned DEF_DEPTH   = 256;
  localparam int unsigned SWEEP_CNT_W = $clog2(DEF_DEPTH);

  typedef enum logic {ST_CLEAR, ST_READY} bram_state_e;

  typedef logic [MAX_DATA_W-1:0] bram_word_t;

  // Mask bit 1 keeps the old bit, 0 takes the new bit.
  function automatic bram_word_t apply_mask(bram_word_t old_w, bram_word_t new_w,
                                            bram_word_t mask_w);
    return (new_w & ~mask_w) | (old_w & mask_w);
  endfunction

  function automatic int unsigned cnt_w(int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/bram_clear_seq.sv
// Post-reset clear sweep: walks addresses 0..DEPTH-1, one per clock, while busy.
module bram_clear_seq
  import bram_pkg::*;
#(
  parameter int unsigned DEPTH          = DEF_DEPTH,
  parameter int unsigned CNT_W          = SWEEP_CNT_W,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             busy_o,
  output logic             clr_we_o,
  output logic [CNT_W-1:0] clr_addr_o
);

  localparam logic [CNT_W-1:0] LAST_ADDR = CNT_W'(DEPTH - 1);
  localparam bram_state_e      RST_STATE = CLEAR_ON_RESET ? ST_CLEAR : ST_READY;

  bram_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RST_STATE;
      cnt_q   <= '0;
      busy_q  <= CLEAR_ON_RESET;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end

  // busy drops on the same edge that writes the last word.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    unique case (state_q)
      ST_CLEAR: begin
        busy_d = 1'b1;
        if (cnt_q == LAST_ADDR) begin
          state_d = ST_READY;
          busy_d  = 1'b0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_READY: busy_d = 1'b0;
      default: begin
        state_d = ST_READY;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign busy_o     = busy_q;
  assign clr_we_o   = busy_q;
  assign clr_addr_o = cnt_q;

endmodule

// File: rtl/bram_sdp_masked.sv
// Parametrised simple-dual-port RAM with bit-masked writes, write-first bypass and clear sweep.
// Define BRAM_OUTREG_EN to add an output register stage (read latency 2).
module bram_sdp_masked
  import bram_pkg::*;
#(
  parameter int unsigned       DATA_W         = 16,
  parameter int unsigned       ADDR_W         = 8,
  parameter int unsigned       DEPTH          = 256,
  parameter bit                CLEAR_ON_RESET = 1'b1,
  parameter logic [DATA_W-1:0] FILL_VALUE     = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic              wclke,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] mask,
  input  logic              re,
  input  logic              rclke,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid,
  output logic              busy
);

  localparam int unsigned     IDX_W   = cnt_w(DEPTH);
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];

  logic              clr_we;
  logic [IDX_W-1:0]  clr_addr;
  logic              wr_qual_c, rd_qual_c, wr_in_c, rd_in_c, coll_c;
  logic [IDX_W-1:0]  widx, ridx;
  logic [DATA_W-1:0] wr_word_c, rd_word_c;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              rvalid_q;

  bram_clear_seq #(
    .DEPTH          (DEPTH),
    .CNT_W          (IDX_W),
    .CLEAR_ON_RESET (CLEAR_ON_RESET)
  ) u_clear_seq (
    .clk        (clk),
    .rst_n      (rst_n),
    .busy_o     (busy),
    .clr_we_o   (clr_we),
    .clr_addr_o (clr_addr)
  );

  assign wr_qual_c = we & wclke & ~busy;
  assign rd_qual_c = re & rclke & ~busy;
  assign wr_in_c   = ({1'b0, waddr} < DEPTH_L);
  assign rd_in_c   = ({1'b0, raddr} < DEPTH_L);
  assign widx      = IDX_W'(waddr);
  assign ridx      = IDX_W'(raddr);
  assign coll_c    = wr_qual_c & wr_in_c & (waddr == raddr);

  assign wr_word_c = DATA_W'(apply_mask(MAX_DATA_W'(mem[widx]), MAX_DATA_W'(wdata),
                                        MAX_DATA_W'(mask)));

  // Same-address write wins bitwise; out-of-range reads return zero.
  always_comb begin
    rd_word_c = '0;
    if (rd_in_c) rd_word_c = coll_c ? wr_word_c : mem[ridx];
    rdata_d = rd_qual_c ? rd_word_c : rdata_q;
  end

  // The sweep owns the write port while busy.
  always_ff @(posedge clk) begin
    if (clr_we) mem[clr_addr] <= FILL_VALUE;
    else if (wr_qual_c && wr_in_c) mem[widx] <= wr_word_c;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      rdata_q  <= rdata_d;
      rvalid_q <= rd_qual_c;
    end
  end

`ifdef BRAM_OUTREG_EN
  logic [DATA_W-1:0] rdata2_q, rdata2_d;
  logic              rvalid2_q;

  assign rdata2_d = rvalid_q ? rdata_q : rdata2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata2_q  <= '0;
      rvalid2_q <= 1'b0;
    end else begin
      rdata2_q  <= rdata2_d;
      rvalid2_q <= rvalid_q;
    end
  end

  assign rdata  = rdata2_q;
  assign rvalid = rvalid2_q;
`else
  assign rdata  = rdata_q;
  assign rvalid = rvalid_q;
`endif

endmodule

// File: tb/tb_bram_sdp_masked.sv
// Randomized bench for bram_sdp_masked against an array-based behavioural model.
module tb_bram_sdp_masked;

  localparam int unsigned DW    = 16;
  localparam int unsigned AW    = 8;
  localparam int unsigned DEPTH = 200;
  localparam logic [15:0] FILL  = 16'hA5A5;
`ifdef BRAM_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          we, wclke, re, rclke;
  logic [AW-1:0] waddr, raddr;
  logic [DW-1:0] wdata, mask;
  logic [DW-1:0] rdata;
  logic          rvalid, busy;

  bram_sdp_masked #(
    .DATA_W         (DW),
    .ADDR_W         (AW),
    .DEPTH          (DEPTH),
    .CLEAR_ON_RESET (1'b1),
    .FILL_VALUE     (FILL)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .we     (we),
    .wclke  (wclke),
    .waddr  (waddr),
    .wdata  (wdata),
    .mask   (mask),
    .re     (re),
    .rclke  (rclke),
    .raddr  (raddr),
    .rdata  (rdata),
    .rvalid (rvalid),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          v;
    logic [DW-1:0] d;
  } ent_t;

  logic [DW-1:0] mem_m [256];
  int            busy_cnt = DEPTH;
  ent_t          pq[$];
  logic          exp_rv = 1'b0;
  logic [DW-1:0] exp_rd = '0;
  int            n_checks = 0;
  int            n_pass = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) $display("FAIL %s: got %h, want %h (t=%0t)", tag, obs, exp, $time);
    else n_pass++;
  endtask

  task automatic drv(input logic w, input logic wc, input logic [AW-1:0] wa,
                     input logic [DW-1:0] wd, input logic [DW-1:0] m,
                     input logic r, input logic rc, input logic [AW-1:0] ra);
    we = w; wclke = wc; waddr = wa; wdata = wd; mask = m;
    re = r; rclke = rc; raddr = ra;
  endtask

  task automatic idle();
    drv(1'b0, 1'b1, '0, '0, '0, 1'b0, 1'b1, '0);
  endtask

  // One clock: advance the model by the request seen at this edge, then compare outputs.
  task automatic step();
    ent_t e;
    logic qw, qr;
    @(posedge clk);
    if (!rst_n) begin
      busy_cnt = DEPTH;
      pq.delete();
      exp_rv = 1'b0;
      exp_rd = '0;
    end else begin
      qw = we & wclke & (busy_cnt == 0);
      qr = re & rclke & (busy_cnt == 0);
      e.v = qr;
      e.d = '0;
      if (qr && raddr < DEPTH) begin
        e.d = mem_m[raddr];
        if (qw && waddr == raddr) e.d = (wdata & ~mask) | (e.d & mask);
      end
      if (busy_cnt > 0) begin
        mem_m[DEPTH - busy_cnt] = FILL;
        busy_cnt--;
      end else if (qw && waddr < DEPTH) begin
        mem_m[waddr] = (wdata & ~mask) | (mem_m[waddr] & mask);
      end
      pq.push_back(e);
      if (pq.size() == LAT) begin
        e = pq.pop_front();
        exp_rv = e.v;
        if (e.v) exp_rd = e.d;
      end
    end
    #1;
    check("busy", 32'(busy), 32'(busy_cnt > 0));
    check("rvalid", 32'(rvalid), 32'(exp_rv));
    check("rdata", 32'(rdata), 32'(exp_rd));
  endtask

  // Issue step for an already-driven read, wait out the latency, check the result.
  task automatic finish_read(input string tag, input logic [DW-1:0] exp);
    step();
    idle();
    repeat (LAT - 1) step();
    check({tag, "_rvalid"}, 32'(rvalid), 32'd1);
    check(tag, 32'(rdata), 32'(exp));
  endtask

  task automatic sweep_len(input string tag);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (busy === 1'b1 && n < 1000);
    check(tag, 32'(n), 32'(DEPTH));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
    $fatal(1);
  end

  initial begin
    idle();
    repeat (3) step();
    check("rst_busy", 32'(busy), 32'd1);

    @(negedge clk) rst_n = 1'b1;
    sweep_len("sweep_len");

    drv(1'b0, 1'b1, '0, '0, '0, 1'b1, 1'b1, 8'h7F);
    finish_read("t1_fill", FILL);

    drv(1'b1, 1'b1, 8'd3, 16'h1234, 16'h0000, 1'b0, 1'b1, '0);
    step();
    drv(1'b1, 1'b1, 8'd3, 16'hFFFF, 16'hFF00, 1'b0, 1'b1, '0);
    step();
    drv(1'b0, 1'b1, '0, '0, '0, 1'b1, 1'b1, 8'd3);
    finish_read("t2_mask", 16'h12FF);

    drv(1'b1, 1'b1, 8'd5, 16'h0000, 16'h0000, 1'b0, 1'b1, '0);
    step();
    drv(1'b1, 1'b1, 8'd5, 16'hBEEF, 16'h000F, 1'b1, 1'b1, 8'd5);
    finish_read("t3_coll", 16'hBEE0);
    drv(1'b0, 1'b1, '0, '0, '0, 1'b1, 1'b1, 8'd5);
    finish_read("t3_later", 16'hBEE0);

    drv(1'b1, 1'b0, 8'd3, 16'h0000, 16'h0000, 1'b1, 1'b0, 8'd3);
    step();
    idle();
    repeat (LAT) step();
    check("t4_rvalid", 32'(rvalid), 32'd0);
    check("t4_hold", 32'(rdata), 32'h0000BEE0);
    drv(1'b0, 1'b1, '0, '0, '0, 1'b1, 1'b1, 8'd3);
    finish_read("t4_mem", 16'h12FF);

    @(negedge clk) rst_n = 1'b0;
    step();
    @(negedge clk) rst_n = 1'b1;
    repeat (100) step();
    @(negedge clk) rst_n = 1'b0;
    step();
    check("t5_rst_busy", 32'(busy), 32'd1);
    @(negedge clk) rst_n = 1'b1;
    drv(1'b1, 1'b1, 8'd7, 16'h5555, 16'h0000, 1'b1, 1'b1, 8'd7);
    sweep_len("t5_sweep_len");
    idle();
    drv(1'b0, 1'b1, '0, '0, '0, 1'b1, 1'b1, 8'd7);
    finish_read("t5_lost_wr", FILL);

    drv(1'b1, 1'b1, 8'd210, 16'h1111, 16'h0000, 1'b0, 1'b1, '0);
    step();
    drv(1'b0, 1'b1, '0, '0, '0, 1'b1, 1'b1, 8'd210);
    finish_read("t6_oor", 16'h0000);
    drv(1'b1, 1'b1, 8'd199, 16'hCAFE, 16'h0000, 1'b0, 1'b1, '0);
    step();
    drv(1'b0, 1'b1, '0, '0, '0, 1'b1, 1'b1, 8'd199);
    finish_read("t6_last", 16'hCAFE);

    for (int i = 0; i < 1500; i++) begin
      logic [AW-1:0] wa, ra;
      logic [DW-1:0] m;
      wa = AW'($urandom_range(0, 219));
      ra = ($urandom_range(0, 3) == 0) ? wa : AW'($urandom_range(0, 219));
      case ($urandom_range(0, 3))
        0:       m = '0;
        1:       m = '1;
        default: m = DW'($urandom);
      endcase
      drv(($urandom_range(0, 2) != 0), ($urandom_range(0, 4) != 0), wa, DW'($urandom), m,
          ($urandom_range(0, 2) != 0), ($urandom_range(0, 4) != 0), ra);
      step();
    end
    idle();
    repeat (LAT + 1) step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
